// File: rtl/chunked_seq_adder.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock through a shared CHUNK-bit adder,
// producing sum, carry-out and signed overflow after WIDTH/CHUNK RUN cycles plus one DONE cycle.
module chunked_seq_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned IdxW = $clog2(N + 1);
  localparam int unsigned OffW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, s_q;
  logic [IdxW-1:0]  idx_q;
  logic             carry_q, c_out_q, ovf_q, busy_q, done_q;

  logic [OffW-1:0]  offset;
  logic [CHUNK-1:0] chunk_a, chunk_b, chunk_sum;
  logic             chunk_carry, msb_cin, last_chunk;

  always_comb begin
    offset = OffW'(idx_q * CHUNK);
    chunk_a = a_q[offset +: CHUNK];
    chunk_b = b_q[offset +: CHUNK];
    {chunk_carry, chunk_sum} = {1'b0, chunk_a} + {1'b0, chunk_b} + {{CHUNK{1'b0}}, carry_q};
    // Carry into the top bit, recovered from the sum bit and both operand bits.
    msb_cin = chunk_sum[CHUNK-1] ^ chunk_a[CHUNK-1] ^ chunk_b[CHUNK-1];
    last_chunk = (idx_q == IdxW'(N - 1));
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      idx_q   <= '0;
      carry_q <= 1'b0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            a_q     <= a;
            b_q     <= sub ? ~b : b;
            // Subtraction is a + ~b + 1, so the seed is forced high and c_in ignored.
            carry_q <= sub | c_in;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          s_q[offset +: CHUNK] <= chunk_sum;
          carry_q <= chunk_carry;
          idx_q   <= idx_q + IdxW'(1);
          if (last_chunk) begin
            c_out_q <= chunk_carry;
            ovf_q   <= msb_cin ^ chunk_carry;
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign s     = s_q;
  assign c_out = c_out_q;
  assign ovf   = ovf_q;

endmodule

// File: tb/tb_chunked_seq_adder.sv
// Bench for chunked_seq_adder: three instances (8/4, 16/4, 8/8) share stimulus and are checked
// against an arithmetic reference model, a constant vector table and hand-written sequences.
module tb_chunked_seq_adder;

  logic        clk = 1'b0;
  logic        reset_n, start, c_in, sub;
  logic [15:0] a, b;

  logic       busy8, done8, cout8, ovf8;
  logic [7:0] s8;
  logic        busy16, done16, cout16, ovf16;
  logic [15:0] s16;
  logic       busy1, done1, cout1, ovf1;
  logic [7:0] s1;

  int errors = 0;
  int checks = 0;

  logic [15:0] got_s8, got_s16;
  logic        got_c8, got_o8, got_c16, got_o16;

  always #5 clk = ~clk;

  chunked_seq_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
    .sub(sub), .busy(busy8), .done(done8), .s(s8), .c_out(cout8), .ovf(ovf8)
  );

  chunked_seq_adder #(.WIDTH(16), .CHUNK(4)) dut16 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a), .b(b), .c_in(c_in),
    .sub(sub), .busy(busy16), .done(done16), .s(s16), .c_out(cout16), .ovf(ovf16)
  );

  chunked_seq_adder #(.WIDTH(8), .CHUNK(8)) dut1 (
    .clk(clk), .reset_n(reset_n), .start(start), .a(a[7:0]), .b(b[7:0]), .c_in(c_in),
    .sub(sub), .busy(busy1), .done(done1), .s(s1), .c_out(cout1), .ovf(ovf1)
  );

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic checkv(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain unsigned sum for s/c_out, true signed arithmetic range test for ovf.
  function automatic void model(input int w, input logic [15:0] av, input logic [15:0] bv,
                                input logic ci, input logic sb, output logic [15:0] s_o,
                                output logic c_o, output logic v_o);
    longint mask, half, ua, ub, bb, t, sa, sv, r;
    mask = (longint'(1) << w) - 1;
    half = longint'(1) << (w - 1);
    ua = longint'(av) & mask;
    ub = longint'(bv) & mask;
    bb = sb ? (~ub & mask) : ub;
    t = ua + bb + (sb ? longint'(1) : longint'(ci));
    s_o = 16'(t & mask);
    c_o = ((t >> w) & 1) != 0;
    sa = (ua >= half) ? ua - 2 * half : ua;
    sv = (ub >= half) ? ub - 2 * half : ub;
    r = sb ? sa - sv : sa + sv + longint'(ci);
    v_o = (r >= half) || (r < -half);
  endfunction

  task automatic run_op(input logic [15:0] av, input logic [15:0] bv, input logic ci,
                        input logic sb);
    logic [15:0] es8, es16;
    logic        ec8, eo8, ec16, eo16;
    model(8, av, bv, ci, sb, es8, ec8, eo8);
    model(16, av, bv, ci, sb, es16, ec16, eo16);
    @(posedge clk); #1;
    a = av; b = bv; c_in = ci; sub = sb; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a = 16'($urandom); b = 16'($urandom); c_in = 1'($urandom); sub = 1'($urandom);
    for (int cyc = 1; cyc <= 6; cyc++) begin
      @(negedge clk);
      check1("done8", done8, cyc == 3);
      check1("busy8", busy8, cyc <= 3);
      check1("done16", done16, cyc == 5);
      check1("busy16", busy16, cyc <= 5);
      check1("done1", done1, cyc == 2);
      check1("busy1", busy1, cyc <= 2);
      if (cyc == 3) begin
        got_s8 = {8'h00, s8}; got_c8 = cout8; got_o8 = ovf8;
        checkv("s8", {8'h00, s8}, es8);
        check1("cout8", cout8, ec8);
        check1("ovf8", ovf8, eo8);
      end
      if (cyc == 5) begin
        got_s16 = s16; got_c16 = cout16; got_o16 = ovf16;
        checkv("s16", s16, es16);
        check1("cout16", cout16, ec16);
        check1("ovf16", ovf16, eo16);
      end
      if (cyc == 2) begin
        checkv("s1", {8'h00, s1}, es8);
        check1("cout1", cout1, ec8);
        check1("ovf1", ovf1, eo8);
      end
    end
    checkv("hold_s8", {8'h00, s8}, es8);
    checkv("hold_s16", s16, es16);
    check1("hold_cout16", cout16, ec16);
    checkv("hold_s1", {8'h00, s1}, es8);
  endtask

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    logic [7:0]  s8;
    logic        c8;
    logic        o8;
    logic [15:0] s16;
    logic        c16;
    logic        o16;
  } vec_t;

  vec_t tbl[8];

  logic [15:0] ops_a[17], ops_b[17];
  logic        ops_c[17], ops_s[17];
  logic [15:0] es;
  logic        ec, eo;

  initial begin
    tbl[0] = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1] = '{16'h007F, 16'h0001, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1, 16'h0080, 1'b0, 1'b0};
    tbl[2] = '{16'h0005, 16'h0007, 1'b1, 1'b1, 8'hFE, 1'b0, 1'b0, 16'hFFFE, 1'b0, 1'b0};
    tbl[3] = '{16'h0007, 16'h0005, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 16'h0002, 1'b1, 1'b0};
    tbl[4] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[5] = '{16'h8080, 16'h8080, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 16'h0100, 1'b1, 1'b1};
    tbl[6] = '{16'h0F0F, 16'h0001, 1'b1, 1'b0, 8'h11, 1'b0, 1'b0, 16'h0F11, 1'b0, 1'b0};
    tbl[7] = '{16'h7F80, 16'h0001, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1, 16'h7F7F, 1'b1, 1'b0};

    reset_n = 1'b0; start = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0;
    #3;
    checkv("rst_s8", {8'h00, s8}, 16'h0000);
    check1("rst_cout8", cout8, 1'b0);
    check1("rst_ovf8", ovf8, 1'b0);
    check1("rst_busy8", busy8, 1'b0);
    check1("rst_done8", done8, 1'b0);
    checkv("rst_s16", s16, 16'h0000);
    #20 reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      run_op(tbl[i].a, tbl[i].b, tbl[i].cin, tbl[i].sub);
      checkv("tbl_s8", got_s8, {8'h00, tbl[i].s8});
      check1("tbl_c8", got_c8, tbl[i].c8);
      check1("tbl_o8", got_o8, tbl[i].o8);
      checkv("tbl_s16", got_s16, tbl[i].s16);
      check1("tbl_c16", got_c16, tbl[i].c16);
      check1("tbl_o16", got_o16, tbl[i].o16);
    end

    // start held high: 8/4 instance accepts every N+2 = 4 edges, each with fresh operands.
    for (int i = 0; i < 17; i++) begin
      ops_a[i] = 16'($urandom); ops_b[i] = 16'($urandom);
      ops_c[i] = 1'($urandom); ops_s[i] = 1'($urandom);
    end
    @(posedge clk); #1;
    a = ops_a[0]; b = ops_b[0]; c_in = ops_c[0]; sub = ops_s[0]; start = 1'b1;
    for (int j = 0; j < 16; j++) begin
      @(posedge clk); #1;
      a = ops_a[j + 1]; b = ops_b[j + 1]; c_in = ops_c[j + 1]; sub = ops_s[j + 1];
      @(negedge clk);
      check1("held_done8", done8, (j % 4) == 2);
      if ((j % 4) == 2) begin
        model(8, ops_a[j - 2], ops_b[j - 2], ops_c[j - 2], ops_s[j - 2], es, ec, eo);
        checkv("held_s8", {8'h00, s8}, es);
        check1("held_cout8", cout8, ec);
        check1("held_ovf8", ovf8, eo);
      end
    end
    start = 1'b0;
    repeat (8) @(posedge clk);

    // Asynchronous reset while chunk 1 is in flight.
    @(posedge clk); #1;
    a = 16'h00AA; b = 16'h0011; c_in = 1'b0; sub = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    checkv("arst_s8", {8'h00, s8}, 16'h0000);
    check1("arst_cout8", cout8, 1'b0);
    check1("arst_ovf8", ovf8, 1'b0);
    check1("arst_busy8", busy8, 1'b0);
    check1("arst_busy16", busy16, 1'b0);
    repeat (2) begin
      @(negedge clk);
      check1("arst_done8", done8, 1'b0);
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      check1("post_rst_done8", done8, 1'b0);
      check1("post_rst_busy8", busy8, 1'b0);
    end
    run_op(16'h0012, 16'h0034, 1'b0, 1'b0);
    checkv("post_rst_s8", got_s8, 16'h0046);

    for (int i = 0; i < 1000; i++) begin
      run_op(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/chunked_seq_adder.md
CHUNKED_SEQ_ADDER -- requirements
Module: chunked_seq_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, total operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4, number of bits added per clock. WIDTH SHALL be an integer multiple of CHUNK. N = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1, single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 The block SHALL have port start, input, 1, request to begin an operation.
REQ-006 The block SHALL have ports a and b, input, WIDTH each, operands.
REQ-007 The block SHALL have port c_in, input, 1, carry-in for add mode.
REQ-008 The block SHALL have port sub, input, 1; 0 = add, 1 = subtract.
REQ-009 The block SHALL have port busy, output, 1; high while an operation is in progress.
REQ-010 The block SHALL have port done, output, 1; one-cycle completion pulse.
REQ-011 The block SHALL have port s, output, WIDTH, result.
REQ-012 The block SHALL have port c_out, output, 1, final carry out of the MSB.
REQ-013 The block SHALL have port ovf, output, 1, signed (two's-complement) overflow.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-015 In IDLE with start=1 at a clock edge, the block SHALL capture the operands, sub and the carry seed, load chunk index 0, and enter RUN.
- captured A = a.
- captured B = b when sub=0, ~b when sub=1.
- carry seed = c_in when sub=0, 1 when sub=1; c_in is ignored in subtract mode.
REQ-016 In each RUN cycle k (k = 0..N-1), the block SHALL add chunk k of A, chunk k of B and the carry register using a CHUNK-bit adder.
- it writes the CHUNK-bit sum into s[k*CHUNK +: CHUNK] and the chunk carry into the carry register.
- it increments k.
REQ-017 After chunk N-1 is processed, the block SHALL enter DONE.
- c_out = carry out of chunk N-1.
- ovf = carry into the MSB XOR carry out of the MSB.
REQ-018 DONE SHALL last exactly one cycle with done=1, then return to IDLE unconditionally.
REQ-019 busy SHALL be 1 in RUN and DONE, and 0 in IDLE.
REQ-020 Latency SHALL be fixed: if start is sampled at edge E, done SHALL be high during the cycle after edge E+N (N+1 edges after acceptance), independent of operand values.
REQ-021 start SHALL be ignored when the state is not IDLE; the in-flight operation and captured operands SHALL be unaffected.
REQ-022 Changes on a, b, c_in and sub after acceptance SHALL NOT affect the result.
REQ-023 s, c_out and ovf SHALL hold their values from the last completed operation until the next operation updates them.
- s SHALL be written chunk by chunk during RUN.
- s SHALL be valid only when done=1 or in IDLE after a completion.
REQ-024 In subtract mode, c_out = 1 SHALL mean no borrow (a >= b unsigned), and c_out = 0 SHALL mean a borrow.
REQ-025 The chunk counter SHALL be ceil(log2(N+1)) bits or wider, and SHALL NOT wrap during an operation.
REQ-026 With CHUNK = WIDTH (N = 1), the block SHALL complete in one RUN cycle plus one DONE cycle.

Reset
REQ-027 reset_n = 0 SHALL immediately, without waiting for a clock edge, force the following:
- state to IDLE.
- s = 0, c_out = 0, ovf = 0, done = 0, busy = 0.
- carry register and chunk counter to 0.
REQ-028 When reset_n is asserted mid-operation, the operation SHALL be discarded with no done pulse, and a start after reset release SHALL run normally.

Verification (WIDTH=8, CHUNK=4 unless stated)
REQ-029 a=0xFF, b=0x01, c_in=0, sub=0, start pulse -> done two cycles later (third cycle after the accepting edge), s=0x00, c_out=1, ovf=0.
REQ-030 a=0x7F, b=0x01, c_in=0, sub=0 -> s=0x80, c_out=0, ovf=1.
REQ-031 a=0x05, b=0x07, sub=1, c_in=1 -> s=0xFE, c_out=0 (borrow), ovf=0; a=0x07, b=0x05, sub=1 -> s=0x02, c_out=1.
REQ-032 start held high continuously with changing operands -> only one operation per IDLE visit; results match the operands captured at each acceptance; done pulses every N+2 cycles.
REQ-033 reset_n pulsed low during RUN chunk 1 -> outputs go to 0 asynchronously; no done pulse; the next operation (0x12 + 0x34) gives s=0x46.
REQ-034 WIDTH=16, CHUNK=4: a=0xFFFF, b=0x0001 -> done after N=4 RUN cycles, s=0x0000, c_out=1; compare 1000 random vectors against a reference sum.
